alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational Alu instance between two requesters (port 0, port 1).
//  Each port has a valid/ready request channel and a valid/ready response channel.
//  Arbitration is round-robin; one operation is in flight at a time.
//  A saturating counter records divide-by-zero events for status readout.
//  Sits between the command sources and the Alu datapath.
// PARAMETERS
//  CNT_W   8  width of dz_count
//  RR_EN   1  1 = round-robin grant; 0 = fixed priority, port 0 wins
// PORTS
//  clk          in   1  single clock; all state updates on rising edge
//  rst          in   1  synchronous, active-high reset
//  req_valid_0  in   1  port 0 request valid
//  req_ready_0  out  1  port 0 request accepted this cycle
//  req_a_0      in   3  port 0 operand A
//  req_b_0      in   3  port 0 operand B
//  req_op_0     in   2  port 0 select: 00 add, 01 sub, 10 mul, 11 rem
//  rsp_valid_0  out  1  port 0 result valid
//  rsp_ready_0  in   1  port 0 result consumed
//  rsp_r_0      out  5  port 0 result (Alu R)
//  rsp_flags_0  out  3  port 0 flags {DZF,ZF,SF}
//  req_*_1, rsp_*_1 -- identical set for port 1
//  busy         out  1  high when state != IDLE
//  dz_count     out  CNT_W  saturating count of completed ops with DZF=1
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (port 0 preferred), every req_ready_*=0,
//   every rsp_valid_*=0, rsp_r_*=0, rsp_flags_*=0, busy=0, dz_count=0.
//   Reset mid-operation abandons the op; no response is delivered.
//  States: IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: grant = the valid port. If both are valid: the port at rr_ptr (RR_EN=1)
//   or port 0 (RR_EN=0). req_ready_g = 1 combinationally for the granted port only.
//   On the handshake: latch A, B, op and owner into op_reg; go to EXEC.
//   If RR_EN=1, rr_ptr <= ~owner.
//  EXEC (1 cycle): Alu is driven from op_reg; capture R and {DZF,ZF,SF} into the
//   owner's rsp registers; set rsp_valid_owner=1; if DZF=1 and dz_count is
//   below max, dz_count += 1; go to RESP.
//  RESP: hold rsp_valid_owner and its data stable until rsp_ready_owner=1.
//   On that handshake: clear rsp_valid_owner and go to IDLE.
//   No new request is accepted in this state.
//  Latency: request handshake in cycle N -> rsp_valid in cycle N+2.
//   Minimum issue interval is 3 cycles (back-to-back with rsp_ready held high).
//  The non-owner port's rsp_valid stays 0 throughout.
//   Its request waits with req_ready=0 and must keep req_* stable while waiting.
//  Alu is fed only from op_reg; it never sees raw request inputs.
//  Result fields pass through unmodified: 5-bit R, flags as produced by Alu.
//  dz_count saturates at 2**CNT_W-1 and never wraps.
//  A request asserted in the same cycle as rsp_ready is not accepted until IDLE.
// STRUCTURE
//  Shared package alu_pkg:
//   - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_REM=2'b11
//   - state typedef {IDLE, EXEC, RESP}
//   - FLAG_SF=0, FLAG_ZF=1, FLAG_DZF=2 bit indices
//  One sub-module: the existing Alu, instantiated once as u_alu.
//  Grant logic stays inline; it is too small to split out.
// TESTING
//  1. Single op: port 0 sends A=3'b011, B=3'b010, op=10; rsp_ready_0=1
//     -> rsp_valid_0 in cycle N+2, rsp_r_0=5'd6, rsp_flags_0=3'b000, busy low after.
//  2. Contention: both valid from reset with RR_EN=1
//     -> grants in order port 0, 1, 0, 1; every response reaches its own port only.
//  3. Backpressure: rsp_ready_0=0 for 5 cycles
//     -> rsp_valid_0 and data stable; req_ready_1 stays 0; port 1 served after release.
//  4. Divide by zero: op=11, B=3'b000
//     -> rsp_flags_0[2]=1 and dz_count increments by 1; with CNT_W=2, 5 such ops -> dz_count=3.
//  5. Reset in EXEC/RESP: assert rst for 1 cycle
//     -> next cycle all outputs at reset values; the abandoned op never responds.
//  6. RR_EN=0 with both ports valid continuously -> port 1 never granted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the Alu arbiter slice.
// Contents:
//   OP_*      operation select encodings driven into the Alu
//   FLAG_*    bit positions inside the 3-bit {DZF,ZF,SF} flag vector
//   state_e   arbiter FSM states
//   op_reg_t  latched operation: operands, select and owning port
//   pack_flags helper that places the individual flags at their indices
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_REM = 2'b11;

    localparam int FLAG_SF  = 0;
    localparam int FLAG_ZF  = 1;
    localparam int FLAG_DZF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] op;
        logic       owner;
    } op_reg_t;

    function automatic logic [2:0] pack_flags(input logic dzf, input logic zf, input logic sf);
        logic [2:0] f;
        f           = 3'b000;
        f[FLAG_DZF] = dzf;
        f[FLAG_ZF]  = zf;
        f[FLAG_SF]  = sf;
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 3-bit Alu shared by both arbiter ports.
// Ports:
//   a, b   in  3  unsigned operands
//   op     in  2  OP_ADD / OP_SUB / OP_MUL / OP_REM
//   r      out 5  result
//   flags  out 3  {DZF,ZF,SF}
// Result rules:
//   add  a+b (never exceeds 14)
//   sub  a-b modulo 32, so a negative difference shows up with SF set
//   mul  a*b clamped to 31 (the 6-bit product can reach 49)
//   rem  a%b; with b==0 the result is 0 and DZF is raised
// SF is r[4], ZF is r==0.
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic [1:0] op,
    output logic [4:0] r,
    output logic [2:0] flags
);

    logic [5:0] prod_s;
    logic [4:0] r_s;
    logic       dzf_s;

    // Operation decode and result formation
    always_comb begin
        prod_s = {3'b000, a} * {3'b000, b};
        r_s    = 5'd0;
        dzf_s  = 1'b0;
        case (op)
            OP_ADD: r_s = {2'b00, a} + {2'b00, b};
            OP_SUB: r_s = {2'b00, a} - {2'b00, b};
            OP_MUL: r_s = (prod_s > 6'd31) ? 5'd31 : prod_s[4:0];
            OP_REM: begin
                if (b == 3'd0) begin
                    r_s   = 5'd0;
                    dzf_s = 1'b1;
                end else begin
                    r_s   = {2'b00, a % b};
                    dzf_s = 1'b0;
                end
            end
            default: begin
                r_s   = 5'd0;
                dzf_s = 1'b0;
            end
        endcase
    end

    assign r     = r_s;
    assign flags = pack_flags(dzf_s, (r_s == 5'd0), r_s[4]);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one Alu between two requesters, one operation in flight at a time.
// Parameters:
//   CNT_W  width of dz_count
//   RR_EN  1: round-robin on contention, 0: port 0 always wins
// Ports (x = 0 / 1):
//   clk, rst          clock, synchronous active-high reset
//   req_valid_x  in   request valid
//   req_ready_x  out  request accepted (combinational, granted port only)
//   req_a_x/b_x  in   3-bit operands
//   req_op_x     in   2-bit operation select
//   rsp_valid_x  out  result valid (registered)
//   rsp_ready_x  in   result consumed
//   rsp_r_x      out  5-bit result
//   rsp_flags_x  out  {DZF,ZF,SF}
//   busy         out  high whenever an operation is being executed or delivered
//   dz_count     out  saturating count of completed divide-by-zero operations
// Flow: IDLE accepts one request and latches it, EXEC captures the Alu output
// into the owner's response registers, RESP holds it until the owner takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [2:0]       req_a_0,
    input  logic [2:0]       req_b_0,
    input  logic [1:0]       req_op_0,
    output logic             rsp_valid_0,
    input  logic             rsp_ready_0,
    output logic [4:0]       rsp_r_0,
    output logic [2:0]       rsp_flags_0,
    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [2:0]       req_a_1,
    input  logic [2:0]       req_b_1,
    input  logic [1:0]       req_op_1,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_1,
    output logic [4:0]       rsp_r_1,
    output logic [2:0]       rsp_flags_1,
    output logic             busy,
    output logic [CNT_W-1:0] dz_count
);

    localparam logic [CNT_W-1:0] DZ_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DZ_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    op_reg_t          op_q, op_d;
    logic             rsp_valid_0_q, rsp_valid_0_d;
    logic             rsp_valid_1_q, rsp_valid_1_d;
    logic [4:0]       rsp_r_0_q, rsp_r_0_d;
    logic [4:0]       rsp_r_1_q, rsp_r_1_d;
    logic [2:0]       rsp_flags_0_q, rsp_flags_0_d;
    logic [2:0]       rsp_flags_1_q, rsp_flags_1_d;
    logic [CNT_W-1:0] dz_count_q, dz_count_d;

    logic             grant_vld_s;
    logic             grant_port_s;
    logic [4:0]       alu_r_s;
    logic [2:0]       alu_flags_s;

    // The Alu only ever sees the latched operation, never the live request pins
    alu_arbiter_alu u_alu (
        .a     (op_q.a),
        .b     (op_q.b),
        .op    (op_q.op),
        .r     (alu_r_s),
        .flags (alu_flags_s)
    );

    // Grant selection: only while idle; on contention rr_ptr (or port 0) wins
    always_comb begin
        grant_vld_s  = 1'b0;
        grant_port_s = 1'b0;
        if (state_q == IDLE) begin
            if (req_valid_0 && req_valid_1) begin
                grant_vld_s  = 1'b1;
                grant_port_s = RR_EN ? rr_ptr_q : 1'b0;
            end else if (req_valid_0) begin
                grant_vld_s  = 1'b1;
                grant_port_s = 1'b0;
            end else if (req_valid_1) begin
                grant_vld_s  = 1'b1;
                grant_port_s = 1'b1;
            end else begin
                grant_vld_s  = 1'b0;
                grant_port_s = 1'b0;
            end
        end else begin
            grant_vld_s  = 1'b0;
            grant_port_s = 1'b0;
        end
    end

    // A granted port is by construction valid, so ready doubles as the handshake
    assign req_ready_0 = grant_vld_s & ~grant_port_s;
    assign req_ready_1 = grant_vld_s &  grant_port_s;

    // Next-state and datapath update for the IDLE -> EXEC -> RESP cycle
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        op_d          = op_q;
        rsp_valid_0_d = rsp_valid_0_q;
        rsp_valid_1_d = rsp_valid_1_q;
        rsp_r_0_d     = rsp_r_0_q;
        rsp_r_1_d     = rsp_r_1_q;
        rsp_flags_0_d = rsp_flags_0_q;
        rsp_flags_1_d = rsp_flags_1_q;
        dz_count_d    = dz_count_q;
        case (state_q)
            IDLE: begin
                if (grant_vld_s) begin
                    op_d.owner = grant_port_s;
                    op_d.a     = grant_port_s ? req_a_1  : req_a_0;
                    op_d.b     = grant_port_s ? req_b_1  : req_b_0;
                    op_d.op    = grant_port_s ? req_op_1 : req_op_0;
                    state_d    = EXEC;
                    if (RR_EN) begin
                        rr_ptr_d = ~grant_port_s;
                    end else begin
                        rr_ptr_d = rr_ptr_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (op_q.owner) begin
                    rsp_valid_1_d = 1'b1;
                    rsp_r_1_d     = alu_r_s;
                    rsp_flags_1_d = alu_flags_s;
                end else begin
                    rsp_valid_0_d = 1'b1;
                    rsp_r_0_d     = alu_r_s;
                    rsp_flags_0_d = alu_flags_s;
                end
                if (alu_flags_s[FLAG_DZF] && (dz_count_q != DZ_MAX)) begin
                    dz_count_d = dz_count_q + DZ_ONE;
                end else begin
                    dz_count_d = dz_count_q;
                end
                state_d = RESP;
            end
            RESP: begin
                // Only the owner's consume ends the transaction; requests wait
                if (op_q.owner ? rsp_ready_1 : rsp_ready_0) begin
                    if (op_q.owner) begin
                        rsp_valid_1_d = 1'b0;
                    end else begin
                        rsp_valid_0_d = 1'b0;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= 1'b0;
            op_q          <= '0;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            rsp_r_0_q     <= 5'd0;
            rsp_r_1_q     <= 5'd0;
            rsp_flags_0_q <= 3'd0;
            rsp_flags_1_q <= 3'd0;
            dz_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            op_q          <= op_d;
            rsp_valid_0_q <= rsp_valid_0_d;
            rsp_valid_1_q <= rsp_valid_1_d;
            rsp_r_0_q     <= rsp_r_0_d;
            rsp_r_1_q     <= rsp_r_1_d;
            rsp_flags_0_q <= rsp_flags_0_d;
            rsp_flags_1_q <= rsp_flags_1_d;
            dz_count_q    <= dz_count_d;
        end
    end

    assign rsp_valid_0 = rsp_valid_0_q;
    assign rsp_valid_1 = rsp_valid_1_q;
    assign rsp_r_0     = rsp_r_0_q;
    assign rsp_r_1     = rsp_r_1_q;
    assign rsp_flags_0 = rsp_flags_0_q;
    assign rsp_flags_1 = rsp_flags_1_q;
    assign busy        = (state_q != IDLE);
    assign dz_count    = dz_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a round-robin instance (CNT_W=2) checked every
// cycle against a transaction-level reference model, plus a fixed-priority
// instance driven with continuous contention.
module tb_alu_arbiter;

    localparam int TB_CNT_W = 2;
    localparam int DZ_SAT   = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Round-robin instance signals
    logic       req_valid [2];
    logic       req_ready [2];
    logic [2:0] req_a     [2];
    logic [2:0] req_b     [2];
    logic [1:0] req_op    [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [4:0] rsp_r     [2];
    logic [2:0] rsp_flags [2];
    logic       busy;
    logic [TB_CNT_W-1:0] dz_count;

    // Fixed-priority instance signals
    logic       f_req_valid [2];
    logic       f_req_ready [2];
    logic [2:0] f_req_a     [2];
    logic [2:0] f_req_b     [2];
    logic [1:0] f_req_op    [2];
    logic       f_rsp_valid [2];
    logic       f_rsp_ready [2];
    logic [4:0] f_rsp_r     [2];
    logic [2:0] f_rsp_flags [2];
    logic       f_busy;
    logic [7:0] f_dz_count;

    alu_arbiter #(.CNT_W(TB_CNT_W), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid[0]), .req_ready_0(req_ready[0]), .req_a_0(req_a[0]),
        .req_b_0(req_b[0]), .req_op_0(req_op[0]), .rsp_valid_0(rsp_valid[0]),
        .rsp_ready_0(rsp_ready[0]), .rsp_r_0(rsp_r[0]), .rsp_flags_0(rsp_flags[0]),
        .req_valid_1(req_valid[1]), .req_ready_1(req_ready[1]), .req_a_1(req_a[1]),
        .req_b_1(req_b[1]), .req_op_1(req_op[1]), .rsp_valid_1(rsp_valid[1]),
        .rsp_ready_1(rsp_ready[1]), .rsp_r_1(rsp_r[1]), .rsp_flags_1(rsp_flags[1]),
        .busy(busy), .dz_count(dz_count)
    );

    alu_arbiter #(.CNT_W(8), .RR_EN(1'b0)) dut_f (
        .clk(clk), .rst(rst),
        .req_valid_0(f_req_valid[0]), .req_ready_0(f_req_ready[0]), .req_a_0(f_req_a[0]),
        .req_b_0(f_req_b[0]), .req_op_0(f_req_op[0]), .rsp_valid_0(f_rsp_valid[0]),
        .rsp_ready_0(f_rsp_ready[0]), .rsp_r_0(f_rsp_r[0]), .rsp_flags_0(f_rsp_flags[0]),
        .req_valid_1(f_req_valid[1]), .req_ready_1(f_req_ready[1]), .req_a_1(f_req_a[1]),
        .req_b_1(f_req_b[1]), .req_op_1(f_req_op[1]), .rsp_valid_1(f_rsp_valid[1]),
        .rsp_ready_1(f_rsp_ready[1]), .rsp_r_1(f_rsp_r[1]), .rsp_flags_1(f_rsp_flags[1]),
        .busy(f_busy), .dz_count(f_dz_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: one outstanding transaction, accepted at cycle m_acc,
    // whose response becomes visible two cycles later.
    bit         m_busy  = 1'b0;
    bit         m_rr    = 1'b0;
    int         m_owner = 0;
    int         m_acc   = 0;
    int         m_dz    = 0;
    logic [4:0] m_r     = 5'd0;
    logic [2:0] m_f     = 3'd0;
    int         acc_port = -1;
    int         glog[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void ref_alu(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                                    output logic [4:0] r, output logic [2:0] f);
        int ia, ib, v;
        bit dz;
        ia = int'(a);
        ib = int'(b);
        dz = 1'b0;
        case (op)
            2'd0:    v = ia + ib;
            2'd1:    v = (ia - ib + 32) % 32;
            2'd2:    v = (ia * ib > 31) ? 31 : ia * ib;
            default: begin
                if (ib == 0) begin
                    v  = 0;
                    dz = 1'b1;
                end else begin
                    v = ia % ib;
                end
            end
        endcase
        r = v[4:0];
        f = {dz, (v == 0), r[4]};
    endfunction

    function automatic int exp_grant();
        if (m_busy) return -1;
        if (req_valid[0] && req_valid[1]) return int'(m_rr);
        if (req_valid[0]) return 0;
        if (req_valid[1]) return 1;
        return -1;
    endfunction

    task automatic check_outputs();
        int g;
        bit ev;
        g = exp_grant();
        for (int p = 0; p < 2; p++) begin
            ev = m_busy && (m_owner == p) && (cyc >= m_acc + 2);
            chk($sformatf("req_ready_%0d", p), {7'd0, req_ready[p]}, {7'd0, (g == p)});
            chk($sformatf("rsp_valid_%0d", p), {7'd0, rsp_valid[p]}, {7'd0, ev});
            if (ev) begin
                chk($sformatf("rsp_r_%0d", p), {3'd0, rsp_r[p]}, {3'd0, m_r});
                chk($sformatf("rsp_flags_%0d", p), {5'd0, rsp_flags[p]}, {5'd0, m_f});
            end
        end
        chk("busy", {7'd0, busy}, {7'd0, m_busy});
        chk("dz_count", {6'd0, dz_count}, 8'(m_dz));
    endtask

    task automatic update_model();
        int g;
        acc_port = -1;
        if (rst) begin
            m_busy = 1'b0;
            m_rr   = 1'b0;
            m_dz   = 0;
            return;
        end
        g = exp_grant();
        if (m_busy) begin
            if ((cyc == m_acc + 1) && m_f[2] && (m_dz < DZ_SAT)) m_dz++;
            if ((cyc >= m_acc + 2) && rsp_ready[m_owner]) m_busy = 1'b0;
        end else if (g >= 0) begin
            m_busy  = 1'b1;
            m_owner = g;
            m_acc   = cyc;
            ref_alu(req_a[g], req_b[g], req_op[g], m_r, m_f);
            m_rr    = (g == 0);
            acc_port = g;
            glog.push_back(g);
        end
    endtask

    // One clock: check at the falling edge, advance the model, resume after the rising edge
    task automatic cycle();
        @(negedge clk);
        if (!rst) check_outputs();
        update_model();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic reset_chk(input string tag);
        for (int p = 0; p < 2; p++) begin
            chk({tag, "_req_ready"}, {7'd0, req_ready[p]}, 8'd0);
            chk({tag, "_rsp_valid"}, {7'd0, rsp_valid[p]}, 8'd0);
            chk({tag, "_rsp_r"},     {3'd0, rsp_r[p]},     8'd0);
            chk({tag, "_rsp_flags"}, {5'd0, rsp_flags[p]}, 8'd0);
        end
        chk({tag, "_busy"},     {7'd0, busy},     8'd0);
        chk({tag, "_dz_count"}, {6'd0, dz_count}, 8'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        cycle();
        rst = 1'b0;
        reset_chk(tag);
    endtask

    task automatic issue(input int p, input logic [2:0] a, input logic [2:0] b, input logic [1:0] op);
        bit got;
        got = 1'b0;
        req_a[p] = a;
        req_b[p] = b;
        req_op[p] = op;
        req_valid[p] = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle();
            if (acc_port == p) got = 1'b1;
        end
        chk("issue_accept", {7'd0, got}, 8'd1);
        req_valid[p] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] held_r;
        logic [2:0] held_f;
        int f_rsp_cnt, f_acc_cnt, e;
        bit got;

        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'b0; req_a[p] = 3'd0; req_b[p] = 3'd0; req_op[p] = 2'd0;
            rsp_ready[p] = 1'b0;
            f_req_valid[p] = 1'b0; f_req_a[p] = 3'd0; f_req_b[p] = 3'd0; f_req_op[p] = 2'd0;
            f_rsp_ready[p] = 1'b0;
        end
        #1;

        // Reset state
        do_reset("rst0");

        // Single multiply: 3*2 = 6, response two cycles after the handshake
        rsp_ready[0] = 1'b1;
        issue(0, 3'b011, 3'b010, 2'b10);
        run(1);
        chk("t1_valid", {7'd0, rsp_valid[0]}, 8'd1);
        chk("t1_r",     {3'd0, rsp_r[0]},     8'd6);
        chk("t1_flags", {5'd0, rsp_flags[0]}, 8'd0);
        run(1);
        chk("t1_busy_after", {7'd0, busy}, 8'd0);

        // Contention from reset: grants alternate 0,1,0,1
        do_reset("rst1");
        glog.delete();
        rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;
        req_a[0] = 3'd5; req_b[0] = 3'd6; req_op[0] = 2'b00;
        req_a[1] = 3'd2; req_b[1] = 3'd7; req_op[1] = 2'b01;
        req_valid[0] = 1'b1; req_valid[1] = 1'b1;
        for (int k = 0; k < 40 && glog.size() < 4; k++) cycle();
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        chk("t2_grant_count", 8'(glog.size()), 8'd4);
        if (glog.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("t2_grant_%0d", i), 8'(glog[i]), 8'(i % 2));
        end
        run(3);

        // Backpressure on port 0 while port 1 waits
        rsp_ready[0] = 1'b0; rsp_ready[1] = 1'b1;
        issue(0, 3'd7, 3'd7, 2'b10);
        req_a[1] = 3'd6; req_b[1] = 3'd4; req_op[1] = 2'b11;
        req_valid[1] = 1'b1;
        run(1);
        held_r = rsp_r[0];
        held_f = rsp_flags[0];
        chk("t3_sat_mul", {3'd0, held_r}, 8'd31);
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid_held", {7'd0, rsp_valid[0]}, 8'd1);
            chk("t3_r_stable", {3'd0, rsp_r[0]}, {3'd0, held_r});
            chk("t3_f_stable", {5'd0, rsp_flags[0]}, {5'd0, held_f});
            chk("t3_port1_blocked", {7'd0, req_ready[1]}, 8'd0);
            cycle();
        end
        rsp_ready[0] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle();
            if (acc_port == 1) got = 1'b1;
        end
        chk("t3_port1_served", {7'd0, got}, 8'd1);
        req_valid[1] = 1'b0;
        run(3);

        // Divide by zero five times: counter saturates at 3
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(0, 3'($urandom_range(7)), 3'd0, 2'b11);
            run(1);
            e = (i + 1 > DZ_SAT) ? DZ_SAT : i + 1;
            chk("t4_dzf", {7'd0, rsp_flags[0][2]}, 8'd1);
            chk("t4_dz_count", {6'd0, dz_count}, 8'(e));
            run(1);
        end

        // Reset while in EXEC, then while in RESP: abandoned op never responds
        rsp_ready[1] = 1'b0;
        issue(1, 3'd4, 3'd3, 2'b00);
        do_reset("t5_exec");
        rsp_ready[1] = 1'b1;
        run(5);
        rsp_ready[1] = 1'b0;
        issue(1, 3'd1, 3'd5, 2'b01);
        run(1);
        do_reset("t5_resp");
        rsp_ready[1] = 1'b1;
        run(5);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] && ($urandom_range(2) == 0)) begin
                    req_valid[p] = 1'b1;
                    req_a[p]  = 3'($urandom_range(7));
                    req_b[p]  = ($urandom_range(3) == 0) ? 3'd0 : 3'($urandom_range(7));
                    req_op[p] = 2'($urandom_range(3));
                end
                rsp_ready[p] = 1'($urandom_range(1));
            end
            cycle();
            if (acc_port >= 0) req_valid[acc_port] = 1'b0;
        end
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;
        run(4);

        // Fixed priority: port 1 is never granted under continuous contention
        f_req_a[0] = 3'd5; f_req_b[0] = 3'd3; f_req_op[0] = 2'b00;
        f_req_a[1] = 3'd1; f_req_b[1] = 3'd1; f_req_op[1] = 2'b00;
        f_rsp_ready[0] = 1'b1; f_rsp_ready[1] = 1'b1;
        f_req_valid[0] = 1'b1; f_req_valid[1] = 1'b1;
        f_rsp_cnt = 0;
        f_acc_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("t6_req_ready_1", {7'd0, f_req_ready[1]}, 8'd0);
            chk("t6_rsp_valid_1", {7'd0, f_rsp_valid[1]}, 8'd0);
            chk("t6_busy", {7'd0, f_busy}, {7'd0, (i % 3 != 0)});
            if (f_req_ready[0]) f_acc_cnt++;
            if (f_rsp_valid[0]) begin
                f_rsp_cnt++;
                chk("t6_r0", {3'd0, f_rsp_r[0]}, 8'd8);
                chk("t6_f0", {5'd0, f_rsp_flags[0]}, 8'd0);
            end
            @(posedge clk);
            #1;
        end
        chk("t6_accepts", 8'(f_acc_cnt), 8'd10);
        chk("t6_responses", 8'(f_rsp_cnt), 8'd10);
        chk("t6_dz_count", f_dz_count, 8'd0);
        chk("t6_r1_untouched", {3'd0, f_rsp_r[1]}, 8'd0);
        chk("t6_f1_untouched", {5'd0, f_rsp_flags[1]}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
